// File: rtl/iobus_ctrl_pkg.sv
// Shared types and defaults for the half-duplex io_bus direction controller.
package iobus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_TURN,
    TX_XFER,
    RX_TURN,
    RX_XFER
  } state_t;

  // Pad direction encoding as seen on the select output.
  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  localparam int TURN_CYC_DEF    = 2;
  localparam int BURST_MAX_DEF   = 8;
  localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/iobus_nibble_packer.sv
// Assembles received nibbles into bytes, first nibble in the high half.
// flush emits a held lone nibble as {nib,4'h0} with odd set; clear drops it silently.
module iobus_nibble_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       flush,
  input  logic       clear,
  input  logic [3:0] nib,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       odd
);

  logic [3:0] hi_nib;
  logic       have_hi;

  // Pair nibbles; a strobe arriving with flush is packed before the flush is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_nib     <= 4'h0;
      have_hi    <= 1'b0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      odd        <= 1'b0;
    end else if (clear) begin
      have_hi    <= 1'b0;
      byte_valid <= 1'b0;
      odd        <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      odd        <= 1'b0;
      if (push && have_hi) begin
        rx_byte    <= {hi_nib, nib};
        byte_valid <= 1'b1;
        have_hi    <= 1'b0;
      end else if (push && flush) begin
        rx_byte    <= {nib, 4'h0};
        byte_valid <= 1'b1;
        odd        <= 1'b1;
        have_hi    <= 1'b0;
      end else if (push) begin
        hi_nib  <= nib;
        have_hi <= 1'b1;
      end else if (flush && have_hi) begin
        rx_byte    <= {hi_nib, 4'h0};
        byte_valid <= 1'b1;
        odd        <= 1'b1;
        have_hi    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iobus_dir_ctrl.sv
// Half-duplex direction controller for the shared 4-bit FPGA io_bus.
// Every direction change passes through a turnaround state with bus_oe low.
// Optional RX watchdog: define IOBUS_TIMEOUT_EN to enable it (rx_abort tied low otherwise).
module iobus_dir_ctrl
  import iobus_ctrl_pkg::*;
#(
  parameter int TURN_CYC    = TURN_CYC_DEF,
  parameter int BURST_MAX   = BURST_MAX_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [3:0] tx_nib,
  output logic       tx_ready,
  input  logic       rx_req,
  input  logic       rx_stb,
  input  logic [3:0] bus_in,
  output logic       select,
  output logic       bus_oe,
  output logic [3:0] bus_out,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_odd,
  output logic       rx_abort,
  output logic       busy
);

  localparam int TURN_W = $clog2(TURN_CYC + 1);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  state_t              state;
  logic                last_grant;
  logic [TURN_W-1:0]   turn_cnt;
  logic [BEAT_W-1:0]   beats;
  logic                rx_req_eff;
  logic                timeout_hit;
  logic                burst_full;
  logic                tx_accept;
  logic                tx_exit;
  logic                rx_exit;
  logic                turn_done;

`ifdef IOBUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            rx_block;

  // A request that timed out must be withdrawn before it can win arbitration again.
  assign rx_req_eff  = rx_req & ~rx_block;
  assign timeout_hit = (state == RX_XFER) && rx_req && !rx_stb &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts strobe-free RX_XFER cycles and latches the re-request block.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt   <= '0;
      rx_block <= 1'b0;
      rx_abort <= 1'b0;
    end else begin
      rx_abort <= timeout_hit;
      if (state != RX_XFER || rx_stb) to_cnt <= '0;
      else                            to_cnt <= to_cnt + 1'b1;
      if (timeout_hit)  rx_block <= 1'b1;
      else if (!rx_req) rx_block <= 1'b0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_CYC[0];
  assign rx_req_eff         = rx_req;
  assign timeout_hit        = 1'b0;
  assign rx_abort           = 1'b0;
`endif

  assign burst_full = (beats == BEAT_W'(BURST_MAX));
  assign tx_accept  = (state == TX_XFER) && tx_valid && !(burst_full && rx_req_eff);
  assign tx_exit    = (state == TX_XFER) && (!tx_valid || (burst_full && rx_req_eff));
  assign rx_exit    = (state == RX_XFER) && !rx_req;
  assign turn_done  = (turn_cnt == TURN_W'(TURN_CYC - 1));
  assign tx_ready   = tx_accept;
  assign busy       = (state != IDLE);

  // Direction FSM: arbitration, turnaround timing, burst limit and registered pad controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      select     <= DIR_RX;
      bus_oe     <= 1'b0;
      bus_out    <= 4'h0;
      last_grant <= DIR_RX;
      turn_cnt   <= '0;
      beats      <= '0;
    end else begin
      case (state)
        IDLE: begin
          turn_cnt <= '0;
          if (tx_valid && (!rx_req_eff || last_grant == DIR_RX)) begin
            state  <= TX_TURN;
            select <= DIR_TX;
          end else if (rx_req_eff) begin
            state  <= RX_TURN;
            select <= DIR_RX;
          end
        end
        TX_TURN: begin
          if (turn_done) begin
            state  <= TX_XFER;
            bus_oe <= 1'b1;
            beats  <= '0;
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        TX_XFER: begin
          if (tx_accept) begin
            bus_out <= tx_nib;
            beats   <= burst_full ? BEAT_W'(1) : beats + 1'b1;
          end
          if (tx_exit) begin
            bus_oe     <= 1'b0;
            last_grant <= DIR_TX;
            turn_cnt   <= '0;
            if (rx_req_eff) begin
              state  <= RX_TURN;
              select <= DIR_RX;
            end else begin
              state <= IDLE;
            end
          end
        end
        RX_TURN: begin
          if (turn_done) state <= RX_XFER;
          else           turn_cnt <= turn_cnt + 1'b1;
        end
        RX_XFER: begin
          if (rx_exit) begin
            last_grant <= DIR_RX;
            turn_cnt   <= '0;
            if (tx_valid) begin
              state  <= TX_TURN;
              select <= DIR_TX;
            end else begin
              state <= IDLE;
            end
          end else if (timeout_hit) begin
            last_grant <= DIR_RX;
            state      <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          bus_oe <= 1'b0;
        end
      endcase
    end
  end

  iobus_nibble_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .push       ((state == RX_XFER) && rx_stb),
    .flush      (rx_exit),
    .clear      (timeout_hit),
    .nib        (bus_in),
    .rx_byte    (rx_byte),
    .byte_valid (rx_byte_valid),
    .odd        (rx_odd)
  );

endmodule

// File: tb/tb_iobus_dir_ctrl.sv
// Self-checking bench for iobus_dir_ctrl: directed vector table plus
// hand-written burst, wrap, reset, random-safety and (optional) watchdog sequences.
`timescale 1ns/1ps
module tb_iobus_dir_ctrl;
  import iobus_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, tx_valid, rx_req, rx_stb;
  logic [3:0] tx_nib, bus_in;
  logic       tx_ready, select, bus_oe, rx_byte_valid, rx_odd, rx_abort, busy;
  logic [3:0] bus_out;
  logic [7:0] rx_byte;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic       rst, tx_valid;
    logic [3:0] tx_nib;
    logic       rx_req, rx_stb;
    logic [3:0] bus_in;
    logic       e_sel, e_oe;
    logic [3:0] e_out;
    logic       e_rdy;
    logic [7:0] e_byte;
    logic       e_val, e_odd, e_busy;
  } vec_t;

  vec_t vecs[$];

  iobus_dir_ctrl dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_nib(tx_nib), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_stb(rx_stb), .bus_in(bus_in), .select(select), .bus_oe(bus_oe),
    .bus_out(bus_out), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_odd(rx_odd),
    .rx_abort(rx_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void add(input logic r, tv, input logic [3:0] tn, input logic rq, rs,
                              input logic [3:0] bi, input logic s, oe, input logic [3:0] o,
                              input logic rdy, input logic [7:0] b, input logic v, od, bz);
    vec_t x;
    x.rst = r; x.tx_valid = tv; x.tx_nib = tn; x.rx_req = rq; x.rx_stb = rs; x.bus_in = bi;
    x.e_sel = s; x.e_oe = oe; x.e_out = o; x.e_rdy = rdy; x.e_byte = b;
    x.e_val = v; x.e_odd = od; x.e_busy = bz;
    vecs.push_back(x);
  endfunction

  task automatic applyStimulus(input logic r, tv, input logic [3:0] tn, input logic rq, rs,
                               input logic [3:0] bi);
    rst = r; tx_valid = tv; tx_nib = tn; rx_req = rq; rx_stb = rs; bus_in = bi;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [18:0] outs();
    return {select, bus_oe, bus_out, tx_ready, rx_byte, rx_byte_valid, rx_odd, busy, rx_abort};
  endfunction

  task automatic doReset();
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    checkOutput(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    state_t hist1, hist2;
    int acc, viol, tx_grants, rx_grants, cyc, seen_val;
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Reset state
    doReset();
    checkOutput("reset_outputs", {13'd0, outs()}, 32'd0);
    checkOutput("reset_state", {29'd0, dut.state}, {29'd0, IDLE});

    // TX burst 1,2,3
    add(0,1,1,0,0,0, 0,0,0,0,8'h00,0,0,0);
    add(0,1,1,0,0,0, 1,0,0,0,8'h00,0,0,1);
    add(0,1,1,0,0,0, 1,0,0,0,8'h00,0,0,1);
    add(0,1,1,0,0,0, 1,1,0,1,8'h00,0,0,1);
    add(0,1,2,0,0,0, 1,1,1,1,8'h00,0,0,1);
    add(0,1,3,0,0,0, 1,1,2,1,8'h00,0,0,1);
    add(0,0,0,0,0,0, 1,1,3,0,8'h00,0,0,1);
    add(0,0,0,0,0,0, 1,0,3,0,8'h00,0,0,0);
    // RX pack A,5,C with a strobe ignored during turnaround
    add(0,0,0,1,0,0, 1,0,3,0,8'h00,0,0,0);
    add(0,0,0,1,1,4'hF, 0,0,3,0,8'h00,0,0,1);
    add(0,0,0,1,0,0, 0,0,3,0,8'h00,0,0,1);
    add(0,0,0,1,1,4'hA, 0,0,3,0,8'h00,0,0,1);
    add(0,0,0,1,1,4'h5, 0,0,3,0,8'h00,0,0,1);
    add(0,0,0,1,0,0, 0,0,3,0,8'hA5,1,0,1);
    add(0,0,0,1,1,4'hC, 0,0,3,0,8'hA5,0,0,1);
    add(0,0,0,1,0,0, 0,0,3,0,8'hA5,0,0,1);
    add(0,0,0,0,0,0, 0,0,3,0,8'hA5,0,0,1);
    add(0,0,0,0,0,0, 0,0,3,0,8'hC0,1,1,0);
    // Strobe on exit completes a byte
    add(0,0,0,1,0,0, 0,0,3,0,8'hC0,0,0,0);
    add(0,0,0,1,0,0, 0,0,3,0,8'hC0,0,0,1);
    add(0,0,0,1,0,0, 0,0,3,0,8'hC0,0,0,1);
    add(0,0,0,1,1,4'h3, 0,0,3,0,8'hC0,0,0,1);
    add(0,0,0,0,1,4'h7, 0,0,3,0,8'hC0,0,0,1);
    add(0,0,0,0,0,0, 0,0,3,0,8'h37,1,0,0);
    // Lone strobe on exit is flushed odd; pending TX takes the bus next
    add(0,0,0,1,0,0, 0,0,3,0,8'h37,0,0,0);
    add(0,0,0,1,0,0, 0,0,3,0,8'h37,0,0,1);
    add(0,0,0,1,0,0, 0,0,3,0,8'h37,0,0,1);
    add(0,1,6,0,1,4'h9, 0,0,3,0,8'h37,0,0,1);
    add(0,1,6,0,0,0, 1,0,3,0,8'h90,1,1,1);
    add(0,1,6,0,0,0, 1,0,3,0,8'h90,0,0,1);
    add(0,1,6,0,0,0, 1,1,3,1,8'h90,0,0,1);
    add(0,0,0,0,0,0, 1,1,6,0,8'h90,0,0,1);
    add(0,0,0,0,0,0, 1,0,6,0,8'h90,0,0,0);
    // Tie after a TX grant goes to RX
    add(0,1,5,1,0,0, 1,0,6,0,8'h90,0,0,0);
    add(0,0,0,0,0,0, 0,0,6,0,8'h90,0,0,1);
    add(0,0,0,0,0,0, 0,0,6,0,8'h90,0,0,1);
    add(0,0,0,0,0,0, 0,0,6,0,8'h90,0,0,1);
    add(0,0,0,0,0,0, 0,0,6,0,8'h90,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].rst, vecs[i].tx_valid, vecs[i].tx_nib,
                    vecs[i].rx_req, vecs[i].rx_stb, vecs[i].bus_in);
      #1;
      checkOutput($sformatf("vec%0d", i), {13'd0, outs()},
                  {13'd0, vecs[i].e_sel, vecs[i].e_oe, vecs[i].e_out, vecs[i].e_rdy,
                   vecs[i].e_byte, vecs[i].e_val, vecs[i].e_odd, vecs[i].e_busy, 1'b0});
    end

    // Both requests from reset: TX first, 8 nibbles, turnaround, RX grant
    doReset();
    acc = 0;
    for (int c = 0; c < 15; c++) begin
      logic [3:0] e_out;
      @(negedge clk);
      applyStimulus(0, 1, 4'(c - 2), 1, 0, 0);
      #1;
      if (tx_ready) acc++;
      e_out = (c <= 3) ? 4'd0 : (c <= 11) ? 4'(c - 3) : 4'd8;
      checkOutput($sformatf("burst_c%0d", c),
                  {25'd0, select, bus_oe, tx_ready, e_out == bus_out, busy},
                  {25'd0, (c >= 1 && c <= 11), (c >= 3 && c <= 11),
                   (c >= 3 && c <= 10), 1'b1, (c >= 1)});
    end
    checkOutput("burst_count", acc, 8);
    checkOutput("burst_rx_grant", {29'd0, dut.state}, {29'd0, RX_XFER});
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0);
    waitIdle("burst_release_idle");

    // Burst counter wraps when RX is silent, then limits once RX asks
    acc = 0; cyc = 0;
    while (cyc < 60 && !(acc > 0 && dut.state != TX_XFER && dut.state != TX_TURN)) begin
      @(negedge clk);
      applyStimulus(0, 1, 4'((acc % 7) + 1), (acc >= 10), 0, 0);
      #1;
      if (tx_ready) acc++;
      cyc++;
    end
    checkOutput("wrap_count", acc, 16);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0);
    waitIdle("wrap_release_idle");

    // Reset in the middle of RX with one nibble held
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      case (c)
        3: applyStimulus(0, 0, 0, 1, 1, 4'hA);
        4: applyStimulus(0, 0, 0, 1, 1, 4'h5);
        5: applyStimulus(0, 0, 0, 1, 1, 4'hB);
        default: applyStimulus(0, 0, 0, 1, 0, 0);
      endcase
    end
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("midrx_reset_outputs", {13'd0, outs()}, 32'd0);
    @(negedge clk); #1;
    checkOutput("midrx_no_flush", {30'd0, rx_byte_valid, rx_odd}, 32'd0);

    // Random traffic: bus_oe only in TX_XFER with select=1, transfers preceded by full turnarounds
    viol = 0; tx_grants = 0; rx_grants = 0;
    hist1 = IDLE; hist2 = IDLE;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      applyStimulus(0, ($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 1), 4'($urandom));
      #1;
      if (bus_oe && (select != DIR_TX || dut.state != TX_XFER)) viol++;
      if (dut.state == TX_XFER && hist1 != TX_XFER) begin
        tx_grants++;
        if (hist1 != TX_TURN || hist2 != TX_TURN) viol++;
      end
      if (dut.state == RX_XFER && hist1 != RX_XFER) begin
        rx_grants++;
        if (hist1 != RX_TURN || hist2 != RX_TURN) viol++;
      end
      hist2 = hist1; hist1 = state_t'(dut.state);
    end
    checkOutput("random_safety", viol, 0);
    checkOutput("random_both_dirs", {30'd0, tx_grants > 0, rx_grants > 0}, 32'd3);

`ifdef IOBUS_TIMEOUT_EN
    // RX watchdog fires after a strobe-free window and blocks re-grant
    doReset();
    cyc = 0; seen_val = 0; acc = -1;
    while (cyc < 100 && acc < 0) begin
      @(negedge clk); applyStimulus(0, 0, 0, 1, 0, 0);
      #1;
      if (rx_byte_valid) seen_val++;
      if (rx_abort) acc = cyc;
      cyc++;
    end
    checkOutput("timeout_cycle", acc, 67);
    checkOutput("timeout_idle", {31'd0, busy}, 32'd0);
    checkOutput("timeout_no_byte", seen_val, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("timeout_block%0d", c), {30'd0, busy, rx_abort}, 32'd0);
    end
`else
    checkOutput("abort_tied_low", {31'd0, rx_abort}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
